// File: rtl/simon_key_sched_ctrl.sv
// Iterative Simon round-key sequencer: streams k0..k(T-1) for encryption, or
// expands first and then rewinds to stream k(T-1)..k0 for decryption.

module simon_key_schedule #(
  parameter int WW  = 16,
  parameter int NKW = 4
) (
  input  logic [NKW-1:0][WW-1:0] win_i,
  input  logic                   mode_i,
  input  logic [WW-1:0]          c_xor_z_i,
  output logic [NKW-1:0][WW-1:0] win_o
);
  logic [WW-1:0] nearWord, rot3, mix, newWord;

  // Reverse mode views the window back-to-front, so one datapath serves both directions.
  always_comb begin
    nearWord = mode_i ? win_i[1] : win_i[NKW-1];
    rot3     = {nearWord[2:0], nearWord[WW-1:3]};
    mix      = rot3 ^ ((NKW == 4) ? (mode_i ? win_i[NKW-1] : win_i[1]) : '0);
    mix      = mix ^ {mix[0], mix[WW-1:1]};
    newWord  = win_i[0] ^ mix ^ c_xor_z_i;
    win_o    = '0;
    for (int j = 0; j < NKW - 1; j++) begin
      win_o[j] = win_i[j+1];
    end
    win_o[NKW-1] = newWord;
  end
endmodule

module simon_key_sched_ctrl #(
  parameter  int WW  = 16,
  parameter  int NKW = 4,
  localparam int T   = (WW == 16) ? 32 :
                       (WW == 24) ? 36 :
                       (WW == 32) ? ((NKW == 3) ? 42 : 44) :
                       (WW == 48) ? ((NKW == 2) ? 52 : 54) :
                                    ((NKW == 2) ? 68 : (NKW == 3) ? 69 : 72),
  localparam int RIW = $clog2(T)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic [NKW*WW-1:0]   key_i,
  output logic                busy_o,
  output logic                rk_valid_o,
  input  logic                rk_ready_i,
  output logic [WW-1:0]       rk_o,
  output logic [RIW-1:0]      rk_idx_o,
  output logic                last_o,
  output logic                done_o
);
  localparam int ZSEL = (WW == 16) ? 0 :
                        (WW == 24) ? ((NKW == 3) ? 0 : 1) :
                        (WW == 32) ? ((NKW == 3) ? 2 : 3) :
                        (WW == 48) ? ((NKW == 2) ? 2 : 3) :
                                     ((NKW == 2) ? 2 : (NKW == 3) ? 3 : 4);

  // Literals are written in published order (first element leftmost), then flipped so bit 0 is first.
  function automatic logic [61:0] zMsbFirst(input int sel);
    case (sel)
      0:       zMsbFirst = 62'b11111010001001010110000111001101111101000100101011000011100110;
      1:       zMsbFirst = 62'b10001110111110010011000010110101000111011111001001100001011010;
      2:       zMsbFirst = 62'b10101111011100000011010010011000101000010001111110010110110011;
      3:       zMsbFirst = 62'b11011011101011000110010111100000010010001010011100110100001111;
      default: zMsbFirst = 62'b11010001111001101011011000100000010111000011001010010011101111;
    endcase
  endfunction

  function automatic logic [61:0] reverse62(input logic [61:0] x);
    logic [61:0] r;
    for (int i = 0; i < 62; i++) begin
      r[i] = x[61-i];
    end
    return r;
  endfunction

  localparam logic [61:0]   ZSEQ  = reverse62(zMsbFirst(ZSEL));
  localparam logic [WW-1:0] CBASE = {{(WW-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {IDLE, PRE, EMIT} state_e;

  state_e                 state_q, state_d;
  logic [NKW-1:0][WW-1:0] win_q, win_d, stepWin;
  logic [5:0]             zc_q, zc_d, zcInc, zcDec, zcSel;
  logic [RIW-1:0]         idx_q, idx_d, cnt_q, cnt_d;
  logic                   mode_q, mode_d, done_q, done_d;
  logic                   revStep, lastKey;
  logic [WW-1:0]          cXorZ;

  // A rewind consumes the z index of the key it recreates, hence the pre-decremented zc.
  always_comb begin
    zcInc   = (zc_q == 6'd61) ? 6'd0 : zc_q + 6'd1;
    zcDec   = (zc_q == 6'd0) ? 6'd61 : zc_q - 6'd1;
    revStep = (state_q == EMIT) && mode_q;
    zcSel   = revStep ? zcDec : zc_q;
    cXorZ   = CBASE | WW'(ZSEQ[zcSel]);
    lastKey = (state_q == EMIT) &&
              (mode_q ? (idx_q == '0) : (idx_q == RIW'(T - 1)));
  end

  simon_key_schedule #(.WW(WW), .NKW(NKW)) u_step (
    .win_i     (win_q),
    .mode_i    (revStep),
    .c_xor_z_i (cXorZ),
    .win_o     (stepWin)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    zc_d    = zc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          win_d  = key_i;
          mode_d = mode_i;
          zc_d   = 6'd0;
          if (mode_i) begin
            cnt_d   = RIW'(T - NKW);
            state_d = PRE;
          end else begin
            idx_d   = '0;
            state_d = EMIT;
          end
        end
      end
      PRE: begin
        win_d = stepWin;
        zc_d  = zcInc;
        cnt_d = cnt_q - 1'b1;
        // Final expansion step also flips the window so w[0] holds k(T-1).
        if (cnt_q == RIW'(1)) begin
          for (int j = 0; j < NKW; j++) begin
            win_d[j] = stepWin[NKW-1-j];
          end
          idx_d   = RIW'(T - 1);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready_i) begin
          win_d = stepWin;
          if (mode_q) begin
            zc_d  = zcDec;
            idx_d = idx_q - 1'b1;
          end else begin
            zc_d  = zcInc;
            idx_d = idx_q + 1'b1;
          end
          if (lastKey) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      zc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      zc_q    <= zc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign rk_valid_o = (state_q == EMIT);
  assign rk_o       = rk_valid_o ? win_q[0] : '0;
  assign rk_idx_o   = idx_q;
  assign last_o     = lastKey;
  assign done_o     = done_q;
endmodule

// File: tb/tb_simon_key_sched_ctrl.sv
// Bench for simon_key_sched_ctrl: four configurations (32/64, 64/96, 128/128, 128/256)
// checked every cycle against a key-array model built from the Simon expansion formula.

module tb_simon_key_sched_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [4];
  logic       mode  [4];
  logic       ready [4];
  logic [255:0] key [4];
  logic       busy  [4];
  logic       valid [4];
  logic       last  [4];
  logic       done  [4];
  logic [15:0] rk0;
  logic [31:0] rk1;
  logic [63:0] rk2, rk3;
  logic [4:0]  idx0;
  logic [5:0]  idx1;
  logic [6:0]  idx2, idx3;
  logic [63:0] rkA  [4];
  logic [7:0]  idxA [4];

  int cfgN [4] = '{16, 32, 64, 64};
  int cfgM [4] = '{4, 3, 2, 4};
  int cfgT [4] = '{32, 42, 68, 72};
  int cfgZ [4] = '{0, 2, 2, 4};

  // Published order: leftmost character is element 0.
  logic [61:0] zMsb [5] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111};

  localparam logic [255:0] K32  = 256'h1918_1110_0908_0100;
  localparam logic [255:0] K96  = 256'h13121110_0b0a0908_03020100;
  localparam logic [255:0] K128 = 256'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] K256 = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [255:0] KBAD = 256'hdead_beef_cafe_f00d;

  simon_key_sched_ctrl #(.WW(16), .NKW(4)) u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .mode_i(mode[0]), .key_i(key[0][63:0]),
    .busy_o(busy[0]), .rk_valid_o(valid[0]), .rk_ready_i(ready[0]), .rk_o(rk0),
    .rk_idx_o(idx0), .last_o(last[0]), .done_o(done[0]));
  simon_key_sched_ctrl #(.WW(32), .NKW(3)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .mode_i(mode[1]), .key_i(key[1][95:0]),
    .busy_o(busy[1]), .rk_valid_o(valid[1]), .rk_ready_i(ready[1]), .rk_o(rk1),
    .rk_idx_o(idx1), .last_o(last[1]), .done_o(done[1]));
  simon_key_sched_ctrl #(.WW(64), .NKW(2)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .mode_i(mode[2]), .key_i(key[2][127:0]),
    .busy_o(busy[2]), .rk_valid_o(valid[2]), .rk_ready_i(ready[2]), .rk_o(rk2),
    .rk_idx_o(idx2), .last_o(last[2]), .done_o(done[2]));
  simon_key_sched_ctrl #(.WW(64), .NKW(4)) u3 (
    .clk_i(clk), .rst_i(rst), .start_i(start[3]), .mode_i(mode[3]), .key_i(key[3]),
    .busy_o(busy[3]), .rk_valid_o(valid[3]), .rk_ready_i(ready[3]), .rk_o(rk3),
    .rk_idx_o(idx3), .last_o(last[3]), .done_o(done[3]));

  always_comb begin
    rkA[0]  = 64'(rk0);
    rkA[1]  = 64'(rk1);
    rkA[2]  = rk2;
    rkA[3]  = rk3;
    idxA[0] = 8'(idx0);
    idxA[1] = 8'(idx1);
    idxA[2] = 8'(idx2);
    idxA[3] = 8'(idx3);
  end

  int total = 0;
  int bad   = 0;
  bit chkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: full expanded key list per instance, plus where the stream should be.
  logic [63:0] kt [4][72];
  bit mBusy [4];
  bit mEmit [4];
  bit mMode [4];
  bit mDone [4];
  int mPos  [4];
  int mPre  [4];
  int hsCnt [4] = '{0, 0, 0, 0};

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n, input logic [63:0] mask);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

  task automatic genKeys(input int c, input logic [255:0] kIn);
    int n, m, t;
    logic [63:0] mask, tmp;
    n = cfgN[c];
    m = cfgM[c];
    t = cfgT[c];
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    for (int i = 0; i < m; i++) kt[c][i] = 64'(kIn >> (i * n)) & mask;
    for (int i = m; i < t; i++) begin
      tmp = ror(kt[c][i-1], 3, n, mask);
      if (m == 4) tmp = tmp ^ kt[c][i-3];
      tmp = tmp ^ ror(tmp, 1, n, mask);
      kt[c][i] = (~kt[c][i-m] & mask) ^ tmp ^ 64'(zMsb[cfgZ[c]][61 - ((i - m) % 62)]) ^ 64'd3;
    end
  endtask

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (rst) begin
        mBusy[c] <= 1'b0;
        mEmit[c] <= 1'b0;
        mDone[c] <= 1'b0;
        mPos[c]  <= 0;
        mPre[c]  <= 0;
      end else begin
        mDone[c] <= 1'b0;
        if (!mBusy[c]) begin
          if (start[c]) begin
            genKeys(c, key[c]);
            mBusy[c] <= 1'b1;
            mMode[c] <= mode[c];
            mPos[c]  <= 0;
            mEmit[c] <= !mode[c];
            mPre[c]  <= cfgT[c] - cfgM[c];
          end
        end else if (!mEmit[c]) begin
          if (mPre[c] == 1) mEmit[c] <= 1'b1;
          mPre[c] <= mPre[c] - 1;
        end else if (ready[c]) begin
          hsCnt[c] <= hsCnt[c] + 1;
          if (mPos[c] == cfgT[c] - 1) begin
            mBusy[c] <= 1'b0;
            mEmit[c] <= 1'b0;
            mDone[c] <= 1'b1;
            mPos[c]  <= 0;
          end else begin
            mPos[c] <= mPos[c] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      for (int c = 0; c < 4; c++) begin
        int e;
        e = mMode[c] ? (cfgT[c] - 1 - mPos[c]) : mPos[c];
        checkOutput($sformatf("busy[%0d]", c), 64'(busy[c]), 64'(mBusy[c]));
        checkOutput($sformatf("valid[%0d]", c), 64'(valid[c]), 64'(mEmit[c]));
        checkOutput($sformatf("done[%0d]", c), 64'(done[c]), 64'(mDone[c]));
        if (mEmit[c]) begin
          checkOutput($sformatf("rk[%0d] i%0d", c, e), rkA[c], kt[c][e]);
          checkOutput($sformatf("idx[%0d]", c), 64'(idxA[c]), 64'(e));
          checkOutput($sformatf("last[%0d]", c), 64'(last[c]), 64'(mPos[c] == cfgT[c] - 1));
        end
      end
    end
  end

  task automatic applyStimulus(input int c, input bit md, input logic [255:0] k);
    start[c] = 1'b1;
    mode[c]  = md;
    key[c]   = k;
    @(posedge clk);
    #1;
    start[c] = 1'b0;
    mode[c]  = ~md;
    key[c]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  logic [63:0] lastKey [4];

  task automatic waitDone(input int c, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (valid[c] && last[c] && ready[c]) lastKey[c] = rkA[c];
    end while (!done[c] && n < budget);
    if (!done[c]) checkOutput($sformatf("done_timeout[%0d]", c), 64'd0, 64'd1);
  endtask

  initial begin
    int cyc, base;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      start[c] = 1'b0;
      mode[c]  = 1'b0;
      ready[c] = 1'b0;
      key[c]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    chkEn = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      checkOutput("reset_busy", 64'(busy[c]), 64'd0);
      checkOutput("reset_valid", 64'(valid[c]), 64'd0);
      checkOutput("reset_rk", rkA[c], 64'd0);
      checkOutput("reset_idx", 64'(idxA[c]), 64'd0);
      checkOutput("reset_last", 64'(last[c]), 64'd0);
    end

    // 32/64 encrypt with ready tied high; pins the model against hand-derived keys.
    ready[0] = 1'b1;
    applyStimulus(0, 1'b0, K32);
    checkOutput("enc_first_valid", 64'(valid[0]), 64'd1);
    checkOutput("enc_first_key", 64'(rk0), 64'h0100);
    checkOutput("model_k1", kt[0][1], 64'h0908);
    checkOutput("model_k2", kt[0][2], 64'h1110);
    checkOutput("model_k3", kt[0][3], 64'h1918);
    checkOutput("model_k4", kt[0][4], 64'h71c3);
    waitDone(0, 100);

    // Decrypt started in the done_o cycle; first key appears 29 cycles after start.
    applyStimulus(0, 1'b1, K32);
    cyc = 1;
    while (!valid[0] && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("dec_latency", 64'(cyc), 64'd29);
    checkOutput("dec_first_idx", 64'(idx0), 64'd31);
    waitDone(0, 100);
    checkOutput("dec_final_key", lastKey[0], 64'h0100);

    // 128/128 and 128/256 in both orders exercise the zc wrap both ways.
    ready[2] = 1'b1;
    ready[3] = 1'b1;
    applyStimulus(2, 1'b0, K128);
    checkOutput("k128_k0", kt[2][0], 64'h0706050403020100);
    checkOutput("k128_k1", kt[2][1], 64'h0f0e0d0c0b0a0908);
    waitDone(2, 200);
    applyStimulus(2, 1'b1, K128);
    waitDone(2, 200);
    checkOutput("k128_dec_final", lastKey[2], 64'h0706050403020100);
    applyStimulus(3, 1'b0, K256);
    waitDone(3, 200);
    applyStimulus(3, 1'b1, K256);
    waitDone(3, 200);
    checkOutput("k256_dec_final", lastKey[3], 64'h0706050403020100);

    // 64/96 under random backpressure, encrypt then decrypt.
    for (int pass = 0; pass < 2; pass++) begin
      base = hsCnt[1];
      ready[1] = 1'($urandom_range(0, 1));
      applyStimulus(1, 1'(pass), K96);
      cyc = 0;
      while (!done[1] && cyc < 600) begin
        ready[1] = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        cyc++;
      end
      checkOutput("bp_done_seen", 64'(done[1]), 64'd1);
      checkOutput("bp_handshakes", 64'(hsCnt[1] - base), 64'd42);
    end

    // Stray starts with a different key during PRE and EMIT must be ignored.
    base = hsCnt[0];
    applyStimulus(0, 1'b1, K32);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, KBAD);
    cyc = 0;
    while (!valid[0] && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, KBAD);
    waitDone(0, 100);
    checkOutput("stray_handshakes", 64'(hsCnt[0] - base), 64'd32);
    checkOutput("stray_final_key", lastKey[0], 64'h0100);

    // Reset while emitting idx 10: outputs clear, no done_o, restart gives k0 again.
    applyStimulus(0, 1'b0, K32);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(valid[0] && idx0 == 5'd10) && cyc < 60);
    checkOutput("reached_idx10", 64'(idx0), 64'd10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy", 64'(busy[0]), 64'd0);
    checkOutput("rst_valid", 64'(valid[0]), 64'd0);
    checkOutput("rst_rk", 64'(rk0), 64'd0);
    checkOutput("rst_idx", 64'(idx0), 64'd0);
    checkOutput("rst_last", 64'(last[0]), 64'd0);
    checkOutput("rst_done", 64'(done[0]), 64'd0);
    @(negedge clk);
    checkOutput("rst_no_done", 64'(done[0]), 64'd0);
    applyStimulus(0, 1'b0, K32);
    checkOutput("restart_key", 64'(rk0), 64'h0100);
    checkOutput("restart_valid", 64'(valid[0]), 64'd1);
    waitDone(0, 100);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
